// File: rtl/dc_stage_pkg.sv
// +----------------------------------------------------------------------+
// | dc_stage_pkg : opcode codes, RV32 major opcodes, buffer state type    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package dc_stage_pkg;

    localparam int OP_W = 6;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [6:0] MOP_LUI    = 7'b0110111;
    localparam logic [6:0] MOP_AUIPC  = 7'b0010111;
    localparam logic [6:0] MOP_JAL    = 7'b1101111;
    localparam logic [6:0] MOP_JALR   = 7'b1100111;
    localparam logic [6:0] MOP_BRANCH = 7'b1100011;
    localparam logic [6:0] MOP_LOAD   = 7'b0000011;
    localparam logic [6:0] MOP_STORE  = 7'b0100011;
    localparam logic [6:0] MOP_OPIMM  = 7'b0010011;
    localparam logic [6:0] MOP_OP     = 7'b0110011;

    // ILLEGAL is code 0 so a reset head register reads as ILLEGAL
    localparam logic [OP_W-1:0] OP_ILLEGAL = 6'd0;
    localparam logic [OP_W-1:0] OP_LUI   = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL   = 6'd3,  OP_JALR  = 6'd4;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'd5,  OP_BNE   = 6'd6,  OP_BLT   = 6'd7,  OP_BGE   = 6'd8;
    localparam logic [OP_W-1:0] OP_BLTU  = 6'd9,  OP_BGEU  = 6'd10;
    localparam logic [OP_W-1:0] OP_LB    = 6'd11, OP_LH    = 6'd12, OP_LW    = 6'd13, OP_LBU   = 6'd14;
    localparam logic [OP_W-1:0] OP_LHU   = 6'd15;
    localparam logic [OP_W-1:0] OP_SB    = 6'd16, OP_SH    = 6'd17, OP_SW    = 6'd18;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'd19, OP_SLTI  = 6'd20, OP_SLTIU = 6'd21, OP_XORI  = 6'd22;
    localparam logic [OP_W-1:0] OP_ORI   = 6'd23, OP_ANDI  = 6'd24, OP_SLLI  = 6'd25, OP_SRLI  = 6'd26;
    localparam logic [OP_W-1:0] OP_SRAI  = 6'd27;
    localparam logic [OP_W-1:0] OP_ADD   = 6'd28, OP_SUB   = 6'd29, OP_SLL   = 6'd30, OP_SLT   = 6'd31;
    localparam logic [OP_W-1:0] OP_SLTU  = 6'd32, OP_XOR   = 6'd33, OP_SRL   = 6'd34, OP_SRA   = 6'd35;
    localparam logic [OP_W-1:0] OP_OR    = 6'd36, OP_AND   = 6'd37;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } fifo_st_e;

endpackage

`default_nettype wire

// File: rtl/dc_stage_if.sv
// +----------------------------------------------------------------------+
// | dc_stage_if : queue-side and dispatch-side handshake of the decoder   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

interface dc_stage_if #(
    parameter int PC_WIDTH      = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int REG_IDX_WIDTH = 5,
    parameter int OP_WIDTH      = 6
);
    logic                     in_valid;
    logic                     in_ready;
    logic [PC_WIDTH-1:0]      in_pc;
    logic [31:0]              in_instr;
    logic                     out_valid;
    logic                     out_ready;
    logic [PC_WIDTH-1:0]      out_pc;
    logic [OP_WIDTH-1:0]      out_op;
    logic [REG_IDX_WIDTH-1:0] out_rd;
    logic [REG_IDX_WIDTH-1:0] out_rs1;
    logic [REG_IDX_WIDTH-1:0] out_rs2;
    logic [DATA_WIDTH-1:0]    out_imm;
    logic                     out_is_sl;
    logic                     out_is_branch;
    logic                     out_is_jump;
    logic                     out_is_illegal;

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_op, out_rd, out_rs1, out_rs2,
               out_imm, out_is_sl, out_is_branch, out_is_jump, out_is_illegal
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_op, out_rd, out_rs1, out_rs2,
               out_imm, out_is_sl, out_is_branch, out_is_jump, out_is_illegal
    );
endinterface

`default_nettype wire

// File: rtl/dc_field_decode.sv
// +----------------------------------------------------------------------+
// | dc_field_decode : combinational RV32I instr -> op/regs/imm/flags      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module dc_field_decode
    import dc_stage_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int REG_IDX_WIDTH = 5,
    parameter int OP_WIDTH      = 6,
    parameter bit SIGN_EXT_IMM  = 1'b1
) (
    input  wire logic [31:0]              i_instr,
    output logic      [OP_WIDTH-1:0]      o_op,
    output logic      [REG_IDX_WIDTH-1:0] o_rd,
    output logic      [REG_IDX_WIDTH-1:0] o_rs1,
    output logic      [REG_IDX_WIDTH-1:0] o_rs2,
    output logic      [DATA_WIDTH-1:0]    o_imm,
    output logic                          o_is_sl,
    output logic                          o_is_branch,
    output logic                          o_is_jump,
    output logic                          o_is_illegal
);
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic            w_s;
    logic [31:0]     w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh;
    logic [31:0]     w_imm32;
    logic [OP_W-1:0] w_op;
    logic            w_ok, w_use_rd, w_use_rs1, w_use_rs2, w_sl, w_br, w_jp;

    assign w_f3 = i_instr[14:12];
    assign w_f7 = i_instr[31:25];
    assign w_s  = i_instr[31];

    // Legacy mode exposes the raw, unshifted fields zero-extended
    assign w_imm_i  = SIGN_EXT_IMM ? {{20{w_s}}, i_instr[31:20]} : {20'b0, i_instr[31:20]};
    assign w_imm_s  = SIGN_EXT_IMM ? {{20{w_s}}, i_instr[31:25], i_instr[11:7]}
                                   : {20'b0, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b  = SIGN_EXT_IMM ? {{19{w_s}}, w_s, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0}
                                   : {20'b0, w_s, i_instr[7], i_instr[30:25], i_instr[11:8]};
    assign w_imm_u  = SIGN_EXT_IMM ? {i_instr[31:12], 12'b0} : {12'b0, i_instr[31:12]};
    assign w_imm_j  = SIGN_EXT_IMM ? {{11{w_s}}, w_s, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0}
                                   : {12'b0, w_s, i_instr[19:12], i_instr[20], i_instr[30:21]};
    assign w_imm_sh = {27'b0, i_instr[24:20]};

    always_comb begin
        w_op      = OP_ILLEGAL;
        w_ok      = FALSE;
        w_use_rd  = FALSE;
        w_use_rs1 = FALSE;
        w_use_rs2 = FALSE;
        w_sl      = FALSE;
        w_br      = FALSE;
        w_jp      = FALSE;
        w_imm32   = 32'b0;
        case (i_instr[6:0])
            MOP_LUI:   begin w_op = OP_LUI;   w_ok = TRUE; w_use_rd = TRUE; w_imm32 = w_imm_u; end
            MOP_AUIPC: begin w_op = OP_AUIPC; w_ok = TRUE; w_use_rd = TRUE; w_imm32 = w_imm_u; end
            MOP_JAL:   begin w_op = OP_JAL;   w_ok = TRUE; w_use_rd = TRUE; w_imm32 = w_imm_j; w_jp = TRUE; end
            MOP_JALR: begin
                w_op = OP_JALR; w_ok = (w_f3 == 3'b000); w_use_rd = TRUE; w_use_rs1 = TRUE;
                w_imm32 = w_imm_i; w_jp = TRUE;
            end
            MOP_BRANCH: begin
                w_ok = TRUE; w_use_rs1 = TRUE; w_use_rs2 = TRUE; w_imm32 = w_imm_b; w_br = TRUE;
                case (w_f3)
                    3'b000:  w_op = OP_BEQ;
                    3'b001:  w_op = OP_BNE;
                    3'b100:  w_op = OP_BLT;
                    3'b101:  w_op = OP_BGE;
                    3'b110:  w_op = OP_BLTU;
                    3'b111:  w_op = OP_BGEU;
                    default: w_ok = FALSE;
                endcase
            end
            MOP_LOAD: begin
                w_ok = TRUE; w_use_rd = TRUE; w_use_rs1 = TRUE; w_imm32 = w_imm_i; w_sl = TRUE;
                case (w_f3)
                    3'b000:  w_op = OP_LB;
                    3'b001:  w_op = OP_LH;
                    3'b010:  w_op = OP_LW;
                    3'b100:  w_op = OP_LBU;
                    3'b101:  w_op = OP_LHU;
                    default: w_ok = FALSE;
                endcase
            end
            MOP_STORE: begin
                w_ok = TRUE; w_use_rs1 = TRUE; w_use_rs2 = TRUE; w_imm32 = w_imm_s; w_sl = TRUE;
                case (w_f3)
                    3'b000:  w_op = OP_SB;
                    3'b001:  w_op = OP_SH;
                    3'b010:  w_op = OP_SW;
                    default: w_ok = FALSE;
                endcase
            end
            MOP_OPIMM: begin
                w_ok = TRUE; w_use_rd = TRUE; w_use_rs1 = TRUE; w_imm32 = w_imm_i;
                case (w_f3)
                    3'b000: w_op = OP_ADDI;
                    3'b010: w_op = OP_SLTI;
                    3'b011: w_op = OP_SLTIU;
                    3'b100: w_op = OP_XORI;
                    3'b110: w_op = OP_ORI;
                    3'b111: w_op = OP_ANDI;
                    3'b001: begin w_op = OP_SLLI; w_ok = (w_f7 == 7'b0); w_imm32 = w_imm_sh; end
                    default: begin
                        w_op    = (w_f7 == 7'b0100000) ? OP_SRAI : OP_SRLI;
                        w_ok    = (w_f7 == 7'b0) || (w_f7 == 7'b0100000);
                        w_imm32 = w_imm_sh;
                    end
                endcase
            end
            MOP_OP: begin
                w_use_rd = TRUE; w_use_rs1 = TRUE; w_use_rs2 = TRUE;
                if (w_f7 == 7'b0) begin
                    w_ok = TRUE;
                    case (w_f3)
                        3'b000:  w_op = OP_ADD;
                        3'b001:  w_op = OP_SLL;
                        3'b010:  w_op = OP_SLT;
                        3'b011:  w_op = OP_SLTU;
                        3'b100:  w_op = OP_XOR;
                        3'b101:  w_op = OP_SRL;
                        3'b110:  w_op = OP_OR;
                        default: w_op = OP_AND;
                    endcase
                end else if (w_f7 == 7'b0100000) begin
                    w_op = (w_f3 == 3'b101) ? OP_SRA : OP_SUB;
                    w_ok = (w_f3 == 3'b000) || (w_f3 == 3'b101);
                end
            end
            default: w_ok = FALSE;
        endcase
    end

    // An illegal encoding carries no fields at all, so nothing stale can leak
    always_comb begin
        o_op         = w_ok ? OP_WIDTH'(w_op) : OP_WIDTH'(OP_ILLEGAL);
        o_rd         = (w_ok && w_use_rd)  ? REG_IDX_WIDTH'(i_instr[11:7])  : '0;
        o_rs1        = (w_ok && w_use_rs1) ? REG_IDX_WIDTH'(i_instr[19:15]) : '0;
        o_rs2        = (w_ok && w_use_rs2) ? REG_IDX_WIDTH'(i_instr[24:20]) : '0;
        o_imm        = '0;
        if (w_ok) begin
            if (SIGN_EXT_IMM) o_imm = DATA_WIDTH'($signed(w_imm32));
            else              o_imm = DATA_WIDTH'(w_imm32);
        end
        o_is_sl      = w_ok && w_sl;
        o_is_branch  = w_ok && w_br;
        o_is_jump    = w_ok && w_jp;
        o_is_illegal = !w_ok;
    end

endmodule

`default_nettype wire

// File: rtl/dc_stage.sv
// +----------------------------------------------------------------------+
// | dc_stage : registered RV32I decode stage with 2-entry skid buffer     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module dc_stage
    import dc_stage_pkg::*;
#(
    parameter int PC_WIDTH      = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int REG_IDX_WIDTH = 5,
    parameter int OP_WIDTH      = 6,
    parameter bit SIGN_EXT_IMM  = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic flush,
    dc_stage_if.slave bus
);
    localparam int ENTRY_W = PC_WIDTH + OP_WIDTH + 3*REG_IDX_WIDTH + DATA_WIDTH + 4;

    logic [OP_WIDTH-1:0]      w_op;
    logic [REG_IDX_WIDTH-1:0] w_rd, w_rs1, w_rs2;
    logic [DATA_WIDTH-1:0]    w_imm;
    logic                     w_sl, w_br, w_jp, w_ill;
    logic [ENTRY_W-1:0]       w_entry;

    fifo_st_e                 r_state, w_state_nxt;
    logic                     r_in_ready;
    logic [ENTRY_W-1:0]       r_head, r_skid;
    logic                     w_push, w_pop, w_load_head, w_head_from_skid, w_load_skid;

    dc_field_decode #(
        .DATA_WIDTH    (DATA_WIDTH),
        .REG_IDX_WIDTH (REG_IDX_WIDTH),
        .OP_WIDTH      (OP_WIDTH),
        .SIGN_EXT_IMM  (SIGN_EXT_IMM)
    ) u_dec (
        .i_instr      (bus.in_instr),
        .o_op         (w_op),
        .o_rd         (w_rd),
        .o_rs1        (w_rs1),
        .o_rs2        (w_rs2),
        .o_imm        (w_imm),
        .o_is_sl      (w_sl),
        .o_is_branch  (w_br),
        .o_is_jump    (w_jp),
        .o_is_illegal (w_ill)
    );

    assign w_entry = {bus.in_pc, w_op, w_rd, w_rs1, w_rs2, w_imm, w_sl, w_br, w_jp, w_ill};
    assign w_push  = bus.in_valid && r_in_ready;
    assign w_pop   = (r_state != ST_EMPTY) && bus.out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_head      = FALSE;
        w_head_from_skid = FALSE;
        w_load_skid      = FALSE;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_push) begin w_state_nxt = ST_ONE; w_load_head = TRUE; end
                ST_ONE: begin
                    if (w_push && w_pop)  w_load_head = TRUE;
                    else if (w_push)      begin w_state_nxt = ST_FULL; w_load_skid = TRUE; end
                    else if (w_pop)       w_state_nxt = ST_EMPTY;
                end
                ST_FULL: if (w_pop) begin
                    w_state_nxt      = ST_ONE;
                    w_load_head      = TRUE;
                    w_head_from_skid = TRUE;
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // in_ready is a flop of the next state, so out_ready never reaches it combinationally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b0;
            r_head     <= '0;
            r_skid     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_FULL);
            if (w_load_head) r_head <= w_head_from_skid ? r_skid : w_entry;
            if (w_load_skid) r_skid <= w_entry;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = (r_state != ST_EMPTY);
    assign {bus.out_pc, bus.out_op, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_imm,
            bus.out_is_sl, bus.out_is_branch, bus.out_is_jump, bus.out_is_illegal} = r_head;

endmodule

`default_nettype wire

// File: tb/tb_dc_stage.sv
// +----------------------------------------------------------------------+
// | tb_dc_stage : directed self-checking bench for dc_stage               |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_dc_stage;
    import dc_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    dc_stage_if bus ();

    dc_stage u_dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    logic [31:0] r_leg_instr = 32'b0;
    logic [5:0]  w_leg_op;
    logic [4:0]  w_leg_rd, w_leg_rs1, w_leg_rs2;
    logic [31:0] w_leg_imm;
    logic        w_leg_sl, w_leg_br, w_leg_jp, w_leg_ill;

    dc_field_decode #(.SIGN_EXT_IMM(1'b0)) u_legacy (
        .i_instr      (r_leg_instr),
        .o_op         (w_leg_op),
        .o_rd         (w_leg_rd),
        .o_rs1        (w_leg_rs1),
        .o_rs2        (w_leg_rs2),
        .o_imm        (w_leg_imm),
        .o_is_sl      (w_leg_sl),
        .o_is_branch  (w_leg_br),
        .o_is_jump    (w_leg_jp),
        .o_is_illegal (w_leg_ill)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_check(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                              input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm, input logic [3:0] flg);
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_instr  = ins;
        bus.in_pc     = pc;
        check({tag, "_in_ready"}, bus.in_ready, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_valid"}, bus.out_valid, 1);
        check({tag, "_pc"},    bus.out_pc, pc);
        check({tag, "_op"},    bus.out_op, op);
        check({tag, "_rd"},    bus.out_rd, rd);
        check({tag, "_rs1"},   bus.out_rs1, rs1);
        check({tag, "_rs2"},   bus.out_rs2, rs2);
        check({tag, "_imm"},   bus.out_imm, imm);
        check({tag, "_flags"}, {bus.out_is_sl, bus.out_is_branch, bus.out_is_jump, bus.out_is_illegal}, flg);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_pc [4];
        int          acc, got, seen;
        logic        take;

        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready",  bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_op",    bus.out_op, 0);
        check("rst_out_imm",   bus.out_imm, 0);
        check("rst_out_pc",    bus.out_pc, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 check("post_rst_ready", bus.in_ready, 1);

        // single decodes: flags = {sl, branch, jump, illegal}
        send_check("addi",  32'hFFF00093, 32'h1000, OP_ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 4'b0000);
        send_check("lui",   32'h123452B7, 32'h1004, OP_LUI,  5'd5, 5'd0, 5'd0, 32'h12345000, 4'b0000);
        send_check("beq",   32'hFE208EE3, 32'h1008, OP_BEQ,  5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 4'b0100);
        send_check("sw",    32'h0020A423, 32'h100C, OP_SW,   5'd0, 5'd1, 5'd2, 32'h00000008, 4'b1000);
        send_check("jal",   32'h008000EF, 32'h1010, OP_JAL,  5'd1, 5'd0, 5'd0, 32'h00000008, 4'b0010);
        send_check("srai",  32'h40525193, 32'h1014, OP_SRAI, 5'd3, 5'd4, 5'd0, 32'h00000005, 4'b0000);
        send_check("sub",   32'h407302B3, 32'h1018, OP_SUB,  5'd5, 5'd6, 5'd7, 32'h00000000, 4'b0000);
        send_check("zero",  32'h00000000, 32'h101C, OP_ILLEGAL, 5'd0, 5'd0, 5'd0, 32'h0, 4'b0001);
        send_check("ld011", 32'h0000B003, 32'h1020, OP_ILLEGAL, 5'd0, 5'd0, 5'd0, 32'h0, 4'b0001);
        send_check("slli7", 32'h02109093, 32'h1024, OP_ILLEGAL, 5'd0, 5'd0, 5'd0, 32'h0, 4'b0001);

        // legacy zero-extended immediates
        r_leg_instr = 32'h123452B7;
        #1;
        check("leg_lui_imm", w_leg_imm, 32'h00012345);
        check("leg_lui_op",  w_leg_op, OP_LUI);
        check("leg_lui_rd",  w_leg_rd, 5);
        r_leg_instr = 32'hFE208EE3;
        #1;
        check("leg_beq_imm", w_leg_imm, 32'h00000FFE);
        check("leg_beq_br",  w_leg_br, 1);

        // stream of 4 with out_ready low for 3 cycles
        exp_pc = '{32'h100, 32'h104, 32'h108, 32'h10C};
        acc = 0;
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            @(negedge clk);
            bus.out_ready = (c >= 3);
            if (c == 2) begin
                check("stall_in_ready", bus.in_ready, 0);
                check("stall_head_pc",  bus.out_pc, 32'h100);
            end
            if (bus.out_valid && bus.out_ready) begin
                check("stream_pc",  bus.out_pc, exp_pc[got]);
                check("stream_imm", bus.out_imm, got + 1);
                got++;
            end
            bus.in_valid = (acc < 4);
            if (acc < 4) begin
                bus.in_pc    = exp_pc[acc];
                bus.in_instr = (32'(acc + 1) << 20) | 32'h00000093;
            end
            take = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1 if (take) acc++;
        end
        check("stream_count", got, 4);
        bus.in_valid = 1'b0;

        // flush while FULL with an incoming instruction
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_pc     = 32'h200;
        bus.in_instr  = 32'h00100093;
        @(negedge clk);
        bus.in_pc     = 32'h204;
        @(negedge clk);
        check("full_in_ready",  bus.in_ready, 0);
        check("full_out_valid", bus.out_valid, 1);
        flush        = 1'b1;
        bus.in_pc    = 32'h2F0;
        @(posedge clk);
        #1 flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("flush_full_valid", bus.out_valid, 0);
        check("flush_full_ready", bus.in_ready, 1);

        // flush while ONE; the flush-cycle input must be dropped
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'h210;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("one_head_pc", bus.out_pc, 32'h210);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'h2F4;
        @(posedge clk);
        #1 flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("flush_drop", seen, 0);

        // async reset while ONE
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_pc     = 32'h300;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        #2 check("pre_rst_valid", bus.out_valid, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_pc",    bus.out_pc, 0);
        check("mid_rst_ready", bus.in_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 check("rerst_ready", bus.in_ready, 1);
        check("rerst_valid", bus.out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
